// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the stream sources and sinks of this codebase:
//   - INT_N_DEF       : default integer width (intN) of stream elements
//   - STREAM_*        : bit positions of the fields of a flattened stream
//                       handshake bundle {last, ready, valid, data}
//   - IDLE/RUN/FIN    : state encoding of the stream source FSMs
// -----------------------------------------------------------------------------
package stream_pkg;

   localparam int INT_N_DEF = 32;

   // Flattened stream bundle layout: data occupies the low INT_N bits,
   // followed by valid, ready and last.
   localparam int STREAM_DATA_LSB  = 0;
   localparam int STREAM_DATA_MSB  = INT_N_DEF - 1;
   localparam int STREAM_VALID_BIT = INT_N_DEF;
   localparam int STREAM_READY_BIT = INT_N_DEF + 1;
   localparam int STREAM_LAST_BIT  = INT_N_DEF + 2;
   localparam int STREAM_W         = INT_N_DEF + 3;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

endpackage

// File: rtl/stream_out_reg.sv
// -----------------------------------------------------------------------------
// stream_out_reg
// Output holding register of a valid/ready stream source. Contents are only
// changed by an explicit load or clear from the owning source, so data/last
// stay stable while the element waits for the consumer.
// Ports:
//   clk, nrst  : clock, asynchronous active-low reset
//   i_load     : capture i_data/i_last and raise o_valid
//   i_clear    : drop o_valid/o_last (data keeps its last value)
//   i_data     : element to present
//   i_last     : element is the last of its sequence
//   o_data     : presented element
//   o_valid    : o_data/o_last valid
//   o_last     : presented element is the last one
// -----------------------------------------------------------------------------
module stream_out_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         i_load,
   input  logic         i_clear,
   input  logic [W-1:0] i_data,
   input  logic         i_last,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   output logic         o_last
);

   logic [W-1:0] r_data;
   logic         r_valid;
   logic         r_last;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
         r_last  <= i_last;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_last  = r_last;

endmodule

// File: rtl/stream_range_src.sv
// -----------------------------------------------------------------------------
// stream_range_src
// Stream source feeding the sum reduction stage. A command (start, step, count)
// is turned into the arithmetic sequence start, start+step, ... of `count`
// elements; the final element carries out_last and a one-cycle done pulse
// follows the final transfer (or a zero-count command).
// Ports:
//   clk, nrst  : clock, asynchronous active-low reset
//   cmd_valid  : command offered
//   cmd_ready  : command accepted when cmd_valid && cmd_ready (registered)
//   start_in   : first element value
//   step_in    : two's complement increment
//   count_in   : number of elements (0 allowed)
//   out_data   : current element
//   out_valid  : out_data/out_last valid
//   out_ready  : consumer accepts the element
//   out_last   : final element of the sequence
//   done       : one-cycle completion pulse
//   busy       : any state other than IDLE
// -----------------------------------------------------------------------------
module stream_range_src
   import stream_pkg::*;
#(
   parameter int INT_N = INT_N_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [INT_N-1:0] start_in,
   input  logic [INT_N-1:0] step_in,
   input  logic [CNT_W-1:0] count_in,
   output logic [INT_N-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             done,
   output logic             busy
);

   logic [1:0]       r_state;
   logic             r_cmd_ready;
   logic [CNT_W-1:0] r_remaining;
   logic [INT_N-1:0] r_step;

   logic             w_accept;
   logic             w_count_zero;
   logic             w_xfer;
   logic             w_load;
   logic             w_clear;
   logic [INT_N-1:0] w_next_data;
   logic             w_next_last;
   logic [INT_N-1:0] w_out_data;
   logic             w_out_valid;
   logic             w_out_last;

   assign w_accept     = cmd_valid && r_cmd_ready && (r_state == IDLE);
   assign w_count_zero = (count_in == '0);
   assign w_xfer       = w_out_valid && out_ready;

   // The output register is loaded either with the first element of a new
   // command or with the successor of an element just transferred.
   assign w_load      = (w_accept && !w_count_zero) || (w_xfer && !w_out_last);
   assign w_clear     = w_xfer && w_out_last;
   assign w_next_data = w_accept ? start_in : (w_out_data + r_step);
   assign w_next_last = w_accept ? (count_in == CNT_W'(1)) : (r_remaining == CNT_W'(1));

   stream_out_reg #(
      .W (INT_N)
   ) u_out_reg (
      .clk     (clk),
      .nrst    (nrst),
      .i_load  (w_load),
      .i_clear (w_clear),
      .i_data  (w_next_data),
      .i_last  (w_next_last),
      .o_data  (w_out_data),
      .o_valid (w_out_valid),
      .o_last  (w_out_last)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state     <= IDLE;
         r_cmd_ready <= 1'b1;
         r_remaining <= '0;
         r_step      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_cmd_ready <= 1'b0;
                  if (w_count_zero) begin
                     r_state <= FIN;
                  end else begin
                     r_step      <= step_in;
                     r_remaining <= count_in - CNT_W'(1);
                     r_state     <= RUN;
                  end
               end
            end
            RUN: begin
               if (w_xfer) begin
                  if (w_out_last) begin
                     r_state <= FIN;
                  end else begin
                     r_remaining <= r_remaining - CNT_W'(1);
                  end
               end
            end
            FIN: begin
               r_state     <= IDLE;
               r_cmd_ready <= 1'b1;
            end
            default: begin
               r_state     <= IDLE;
               r_cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign out_data  = w_out_data;
   assign out_valid = w_out_valid;
   assign out_last  = w_out_last;
   assign done      = (r_state == FIN);
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_stream_range_src.sv
module tb_stream_range_src;

   logic        clk;
   logic        nrst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] start_in;
   logic [31:0] step_in;
   logic [15:0] count_in;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        done;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   int n_xfer  = 0;

   stream_range_src dut (
      .clk       (clk),
      .nrst      (nrst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .start_in  (start_in),
      .step_in   (step_in),
      .count_in  (count_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .done      (done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Counts a transfer seen just before the edge, then samples 1ns after it.
   task automatic tick();
      if (out_valid && out_ready) n_xfer++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic l);
      chk({tag, "_valid"}, 64'(out_valid), 64'(v));
      if (v) chk({tag, "_data"}, 64'(out_data), 64'(d));
      chk({tag, "_last"}, 64'(out_last), 64'(l));
   endtask

   initial begin
      nrst      = 1'b0;
      cmd_valid = 1'b0;
      start_in  = '0;
      step_in   = '0;
      count_in  = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;

      // Reset state
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_last",  64'(out_last),  64'd0);
      chk("rst_data",  64'(out_data),  64'd0);
      chk("rst_done",  64'(done),      64'd0);
      chk("rst_busy",  64'(busy),      64'd0);
      chk("rst_ready", 64'(cmd_ready), 64'd1);

      // start=5 step=1 count=4, consumer always ready
      start_in = 32'd5; step_in = 32'd1; count_in = 16'd4;
      cmd_valid = 1'b1; out_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk_out("t1_e0", 1'b1, 32'd5, 1'b0);
      chk("t1_cmdrdy_run", 64'(cmd_ready), 64'd0);
      chk("t1_busy_run",   64'(busy),      64'd1);
      tick(); chk_out("t1_e1", 1'b1, 32'd6, 1'b0);
      tick(); chk_out("t1_e2", 1'b1, 32'd7, 1'b0);
      tick(); chk_out("t1_e3", 1'b1, 32'd8, 1'b1);
      chk("t1_done_early", 64'(done), 64'd0);
      tick();
      chk_out("t1_fin", 1'b0, 32'd0, 1'b0);
      chk("t1_done",      64'(done),      64'd1);
      chk("t1_cmdrdy_fin", 64'(cmd_ready), 64'd0);
      tick();
      chk("t1_done_once", 64'(done),      64'd0);
      chk("t1_cmdrdy",    64'(cmd_ready), 64'd1);
      chk("t1_busy_idle", 64'(busy),      64'd0);

      // start=10 step=-3 count=3, out_ready 1,0,0,1,1
      n_xfer = 0;
      start_in = 32'd10; step_in = 32'hFFFF_FFFD; count_in = 16'd3;
      cmd_valid = 1'b1; out_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk_out("t2_e0", 1'b1, 32'd10, 1'b0);
      tick(); chk_out("t2_e1", 1'b1, 32'd7, 1'b0);
      out_ready = 1'b0;
      tick(); chk_out("t2_stall1", 1'b1, 32'd7, 1'b0);
      tick(); chk_out("t2_stall2", 1'b1, 32'd7, 1'b0);
      out_ready = 1'b1;
      tick(); chk_out("t2_e2", 1'b1, 32'd4, 1'b1);
      tick();
      chk_out("t2_fin", 1'b0, 32'd0, 1'b0);
      chk("t2_done", 64'(done), 64'd1);
      chk("t2_xfers", 64'(n_xfer), 64'd3);
      tick();

      // count=0: no element, single done pulse
      start_in = 32'd99; step_in = 32'd1; count_in = 16'd0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("t3_valid", 64'(out_valid), 64'd0);
      chk("t3_done",  64'(done),      64'd1);
      chk("t3_cmdrdy0", 64'(cmd_ready), 64'd0);
      tick();
      chk("t3_valid2",  64'(out_valid), 64'd0);
      chk("t3_done_once", 64'(done),    64'd0);
      chk("t3_cmdrdy1", 64'(cmd_ready), 64'd1);

      // wrap-around
      start_in = 32'hFFFF_FFFE; step_in = 32'd1; count_in = 16'd3;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk_out("t4_e0", 1'b1, 32'hFFFF_FFFE, 1'b0);
      tick(); chk_out("t4_e1", 1'b1, 32'hFFFF_FFFF, 1'b0);
      tick(); chk_out("t4_e2", 1'b1, 32'h0000_0000, 1'b1);
      tick(); chk("t4_done", 64'(done), 64'd1);
      tick();

      // reset mid-stream after the 2nd of 5 elements
      start_in = 32'd100; step_in = 32'd2; count_in = 16'd5;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      chk_out("t5_e2", 1'b1, 32'd104, 1'b0);
      #2;
      nrst = 1'b0;
      #1;
      chk("t5_async_valid", 64'(out_valid), 64'd0);
      chk("t5_async_last",  64'(out_last),  64'd0);
      chk("t5_async_busy",  64'(busy),      64'd0);
      chk("t5_async_done",  64'(done),      64'd0);
      @(posedge clk);
      #1;
      chk("t5_rst_done", 64'(done), 64'd0);
      nrst = 1'b1;
      tick();
      chk("t5_post_done",  64'(done),      64'd0);
      chk("t5_post_ready", 64'(cmd_ready), 64'd1);
      start_in = 32'd7; step_in = 32'd0; count_in = 16'd1;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk_out("t5_new", 1'b1, 32'd7, 1'b1);
      tick();
      chk("t5_new_done", 64'(done), 64'd1);
      tick();

      // back-to-back with cmd_valid held high
      n_xfer = 0;
      start_in = 32'd1; step_in = 32'd1; count_in = 16'd2;
      cmd_valid = 1'b1;
      tick();
      start_in = 32'd50; count_in = 16'd1;
      chk_out("t6_a0", 1'b1, 32'd1, 1'b0);
      chk("t6_cmdrdy_a0", 64'(cmd_ready), 64'd0);
      tick();
      chk_out("t6_a1", 1'b1, 32'd2, 1'b1);
      chk("t6_cmdrdy_a1", 64'(cmd_ready), 64'd0);
      tick();
      chk("t6_done_a", 64'(done), 64'd1);
      chk("t6_valid_fin", 64'(out_valid), 64'd0);
      tick();
      chk("t6_idle_valid",  64'(out_valid), 64'd0);
      chk("t6_idle_cmdrdy", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      chk_out("t6_b0", 1'b1, 32'd50, 1'b1);
      chk("t6_cmdrdy_b0", 64'(cmd_ready), 64'd0);
      tick();
      chk("t6_done_b", 64'(done), 64'd1);
      chk("t6_xfers", 64'(n_xfer), 64'd3);
      tick();
      chk("t6_end_busy", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
